// File: rtl/vga_timing_pkg.sv
// Shared constants and helpers for the VGA timing generator.
// Defaults describe 640x480@60 with a 4-clock pixel divider.
package vga_timing_pkg;

   localparam int DEF_CLK_DIV  = 4;
   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;
   localparam int DEF_CW       = 10;

   localparam logic POL_LOW  = 1'b0;
   localparam logic POL_HIGH = 1'b1;

   function automatic int span_total(input int act, input int fp,
                                     input int sw, input int bp);
      return act + fp + sw + bp;
   endfunction

   function automatic int sync_beg(input int act, input int fp);
      return act + fp;
   endfunction

   function automatic int sync_end(input int act, input int fp,
                                   input int sw);
      return act + fp + sw;
   endfunction

endpackage

// File: rtl/vga_timing_gen_sync_delay_line.sv
// Fixed-depth shift register that advances only on its enable.
// Depth 0 is a straight wire; reset loads every stage with RST_VAL.
module sync_delay_line #(
   parameter int               W       = 3,
   parameter int               DEPTH   = 0,
   parameter logic [W-1:0]     RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   if (DEPTH == 0) begin : g_wire
      assign q = d;
   end else begin : g_shift
      logic [W-1:0] stg [DEPTH];

      always_ff @(posedge clk) begin
         if (rst) begin
            for (int i = 0; i < DEPTH; i++) stg[i] <= RST_VAL;
         end else if (en) begin
            stg[0] <= d;
            for (int i = 1; i < DEPTH; i++) stg[i] <= stg[i-1];
         end
      end

      assign q = stg[DEPTH-1];
   end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator with internal pixel-tick divider,
// delayed sync/valid outputs, line/frame pulses and a frame counter.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int   CLK_DIV  = DEF_CLK_DIV,
   parameter int   H_ACTIVE = DEF_H_ACTIVE,
   parameter int   H_FP     = DEF_H_FP,
   parameter int   H_SYNC   = DEF_H_SYNC,
   parameter int   H_BP     = DEF_H_BP,
   parameter int   V_ACTIVE = DEF_V_ACTIVE,
   parameter int   V_FP     = DEF_V_FP,
   parameter int   V_SYNC   = DEF_V_SYNC,
   parameter int   V_BP     = DEF_V_BP,
   parameter logic HS_POL   = POL_LOW,
   parameter logic VS_POL   = POL_LOW,
   parameter int   PIPE     = 0,
   parameter int   CW       = DEF_CW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   output logic          pix_tick,
   output logic [CW-1:0] h_cnt,
   output logic [CW-1:0] v_cnt,
   output logic          valid,
   output logic          hsync,
   output logic          vsync,
   output logic          line_start,
   output logic          frame_start,
   output logic [7:0]    frame_cnt
);

   localparam int H_TOTAL = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
   localparam int HS_BEG  = sync_beg(H_ACTIVE, H_FP);
   localparam int HS_END  = sync_end(H_ACTIVE, H_FP, H_SYNC);
   localparam int VS_BEG  = sync_beg(V_ACTIVE, V_FP);
   localparam int VS_END  = sync_end(V_ACTIVE, V_FP, V_SYNC);
   localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
   localparam logic [2:0]    IDLE     = {1'b0, ~HS_POL, ~VS_POL};

   if (CLK_DIV < 1 || PIPE < 0 || PIPE > 7 ||
       H_TOTAL > 2**CW || V_TOTAL > 2**CW) begin : g_bad_cfg
      $error("vga_timing_gen: illegal parameter set");
   end

   logic [DW-1:0] div;
   logic          adv;
   logic          h_wrap;
   logic          v_wrap;
   logic [CW-1:0] h_nxt;
   logic [CW-1:0] v_nxt;
   logic [2:0]    raw_nxt;
   logic [2:0]    raw;
   logic [2:0]    dly;

   assign adv = en && (div == DIV_LAST);

   // Flags are derived from the counter values about to be loaded so
   // they register in step with h_cnt/v_cnt.
   always_comb begin
      h_wrap = (h_cnt == H_LAST);
      v_wrap = (v_cnt == V_LAST);
      h_nxt  = h_wrap ? '0 : h_cnt + CW'(1);
      v_nxt  = v_cnt;
      if (h_wrap) v_nxt = v_wrap ? '0 : v_cnt + CW'(1);
      raw_nxt[2] = (int'(h_nxt) < H_ACTIVE) && (int'(v_nxt) < V_ACTIVE);
      raw_nxt[1] = (int'(h_nxt) >= HS_BEG && int'(h_nxt) < HS_END)
                   ? HS_POL : ~HS_POL;
      raw_nxt[0] = (int'(v_nxt) >= VS_BEG && int'(v_nxt) < VS_END)
                   ? VS_POL : ~VS_POL;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div         <= '0;
         h_cnt       <= H_LAST;
         v_cnt       <= V_LAST;
         frame_cnt   <= 8'hFF;
         pix_tick    <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         raw         <= IDLE;
      end else begin
         pix_tick    <= adv;
         line_start  <= adv && h_wrap;
         frame_start <= adv && h_wrap && v_wrap;
         if (en) div <= adv ? '0 : div + DW'(1);
         if (adv) begin
            h_cnt <= h_nxt;
            v_cnt <= v_nxt;
            raw   <= raw_nxt;
            if (h_wrap && v_wrap) frame_cnt <= frame_cnt + 8'd1;
         end
      end
   end

   sync_delay_line #(
      .W       (3),
      .DEPTH   (PIPE),
      .RST_VAL (IDLE)
   ) u_dly (
      .clk (clk),
      .rst (rst),
      .en  (adv),
      .d   (raw),
      .q   (dly)
   );

   assign valid = dly[2];
   assign hsync = dly[1];
   assign vsync = dly[0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised bench for vga_timing_gen against a linear pixel-index
// reference model, using a shrunken frame so several frames fit.
module tb_vga_timing_gen;

   localparam int   CLK_DIV = 3;
   localparam int   HA = 8, HFP = 2, HSW = 3, HBP = 2;
   localparam int   VA = 5, VFP = 1, VSW = 2, VBP = 1;
   localparam logic HS_POL = 1'b0;
   localparam logic VS_POL = 1'b1;
   localparam int   PIPE = 2;
   localparam int   CW = 5;
   localparam int   HT = HA + HFP + HSW + HBP;
   localparam int   VT = VA + VFP + VSW + VBP;
   localparam int   TOT = HT * VT;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          en = 1'b0;
   logic          pix_tick;
   logic [CW-1:0] h_cnt;
   logic [CW-1:0] v_cnt;
   logic          valid;
   logic          hsync;
   logic          vsync;
   logic          line_start;
   logic          frame_start;
   logic [7:0]    frame_cnt;

   int checks = 0;
   int passes = 0;
   int cyc = 0;

   int         m_div, m_pos, m_fc;
   logic       m_tick, m_ls, m_fs;
   logic [2:0] hist [0:PIPE];

   vga_timing_gen #(
      .CLK_DIV (CLK_DIV),
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
      .HS_POL  (HS_POL),
      .VS_POL  (VS_POL),
      .PIPE    (PIPE),
      .CW      (CW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .pix_tick   (pix_tick),
      .h_cnt      (h_cnt),
      .v_cnt      (v_cnt),
      .valid      (valid),
      .hsync      (hsync),
      .vsync      (vsync),
      .line_start (line_start),
      .frame_start(frame_start),
      .frame_cnt  (frame_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [2:0] flags_of(input int p);
      int h, v;
      logic act, hs, vs;
      h   = p % HT;
      v   = p / HT;
      act = (h < HA) && (v < VA);
      hs  = (h >= HA + HFP && h < HA + HFP + HSW) ? HS_POL : !HS_POL;
      vs  = (v >= VA + VFP && v < VA + VFP + VSW) ? VS_POL : !VS_POL;
      return {act, hs, vs};
   endfunction

   task automatic model(input logic r, input logic e);
      m_tick = 1'b0;
      m_ls   = 1'b0;
      m_fs   = 1'b0;
      if (r) begin
         m_div = 0;
         m_pos = TOT - 1;
         m_fc  = 255;
         for (int i = 0; i <= PIPE; i++) hist[i] = {1'b0, !HS_POL, !VS_POL};
      end else if (e) begin
         m_tick = (m_div == CLK_DIV - 1);
         m_div  = m_tick ? 0 : m_div + 1;
         if (m_tick) begin
            m_pos = (m_pos + 1) % TOT;
            if (m_pos == 0) m_fc = (m_fc + 1) % 256;
            m_ls = (m_pos % HT == 0);
            m_fs = (m_pos == 0);
            for (int i = PIPE; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = flags_of(m_pos);
         end
      end
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s cyc=%0d got %0d want %0d", tag, cyc, obs, exp);
   endtask

   task automatic step(input logic r, input logic e);
      rst = r;
      en  = e;
      @(posedge clk);
      cyc++;
      model(r, e);
      #1;
      chk("pix_tick", int'(pix_tick), int'(m_tick));
      chk("h_cnt", int'(h_cnt), m_pos % HT);
      chk("v_cnt", int'(v_cnt), m_pos / HT);
      chk("valid", int'(valid), int'(hist[PIPE][2]));
      chk("hsync", int'(hsync), int'(hist[PIPE][1]));
      chk("vsync", int'(vsync), int'(hist[PIPE][0]));
      chk("line_start", int'(line_start), int'(m_ls));
      chk("frame_start", int'(frame_start), int'(m_fs));
      chk("frame_cnt", int'(frame_cnt), m_fc);
   endtask

   initial begin
      step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      for (int i = 0; i < 2 * HT * CLK_DIV; i++) step(1'b0, 1'b1);
      for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
      for (int i = 0; i < 3 * TOT * CLK_DIV; i++) step(1'b0, 1'b1);
      step(1'b1, 1'b1);
      for (int i = 0; i < TOT * CLK_DIV; i++) step(1'b0, 1'b1);
      for (int i = 0; i < 4000; i++) begin
         step(($urandom_range(0, 499) == 0),
              ($urandom_range(0, 5) != 0));
      end
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA timing generator, successor to the fixed 640x480 VgaCtrl plus VgaClockDiv pair. It runs on the system clock and derives its own pixel-tick enable instead of needing a divided clock. Resolution, porches and sync polarity are configurable. Adds a sync/valid pipeline delay to match pixel_gen latency, line/frame start pulses, a run enable and a frame counter for UI animation such as cursor blink. Sits in top between the system clock and pixel_gen.

Parameters:
CLK_DIV, 4, system clocks per pixel (>=1)
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, hsync active level (0 = active-low)
VS_POL, 0, vsync active level
PIPE, 0, pixel-tick delay applied to valid/hsync/vsync (0..7)
CW, 10, h_cnt/v_cnt width

Ports:
clk  in  1  system clock; the block's only clock
rst  in  1  synchronous, active-high reset
en  in  1  run enable; 0 freezes all state
pix_tick  out  1  one-clk strobe per pixel
h_cnt  out  CW  horizontal counter, 0..H_TOTAL-1
v_cnt  out  CW  vertical counter, 0..V_TOTAL-1
valid  out  1  active-video flag, delayed PIPE ticks
hsync  out  1  horizontal sync, delayed PIPE ticks
vsync  out  1  vertical sync, delayed PIPE ticks
line_start  out  1  one-clk pulse when h_cnt becomes 0
frame_start  out  1  one-clk pulse when (h_cnt,v_cnt) becomes (0,0)
frame_cnt  out  8  frame counter, wraps 255->0

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous and active-high.
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Elaboration error if CLK_DIV<1, PIPE>7, or either total exceeds 2^CW.
- Reset state: div=0, h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1, frame_cnt=8'hFF, pix_tick=0, line_start=0, frame_start=0, valid=0. hsync=~HS_POL and vsync=~VS_POL; all pipeline stages are filled with these inactive values. Reset mid-frame returns to this state on the next clk.
- Divider: div counts 0..CLK_DIV-1 while en=1. pix_tick is registered and asserts in the cycle after div==CLK_DIV-1. With CLK_DIV=1, pix_tick = en delayed by one clk.
- Counter advance happens in the same clk edge that raises pix_tick:
  - h increments; at H_TOTAL-1 it wraps to 0 and v increments.
  - v wraps at V_TOTAL-1 to 0, and frame_cnt increments on that wrap.
- Consequently the first tick after reset produces (0,0), frame_start=1 and frame_cnt=0.
- Raw flags, evaluated on the new counter values and registered with them:
  - active = h<H_ACTIVE && v<V_ACTIVE
  - hs_act = H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC
  - vs_act = V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC
- Output levels: hsync = hs_act ? HS_POL : ~HS_POL; vsync likewise with VS_POL.
- Delay line: PIPE-stage shift of {valid,hsync,vsync}, advancing only on pix_tick. PIPE=0 means the outputs are aligned with h_cnt/v_cnt. PIPE=k means the outputs reflect counter values k ticks earlier. h_cnt/v_cnt are never delayed.
- line_start/frame_start: high exactly for the one clk in which the new counter value first appears; not delayed.
- en=0: divider, counters, frame_cnt and pipeline hold. pix_tick, line_start and frame_start are 0. Resumes seamlessly from the held div value when en returns to 1.
- rst has priority over en.

Decomposition:
- Package vga_timing_pkg:
  - default 640x480@60 constants
  - localparam helpers for H_TOTAL/V_TOTAL and sync start/end
  - polarity constants
- Sub-module sync_delay_line: parametrised width and depth (0..7), shift on enable, synchronous reset to a parameter-supplied value. It is instantiated once for the 3-bit {valid,hsync,vsync} vector.

Test Plan:
1. Defaults, release rst → first pix_tick 4 clks later; h_cnt=0, v_cnt=0, frame_start=1 for 1 clk, frame_cnt=0, valid=1, hsync=vsync=1.
2. Run one line → valid falls at h_cnt=640; hsync low for h_cnt 656..751 (96 ticks = 384 clks); line_start period 3200 clks.
3. Run two frames → vsync low for v_cnt 490..491 only; frame_start period 420000 ticks; frame_cnt 0→1; v wraps at 524.
4. PIPE=2 → valid falls when h_cnt=642, rises when h_cnt=2 on line 0; hsync low window h_cnt 658..753.
5. en=0 for 10 clks at h_cnt=100 → h_cnt stays 100, no pix_tick/line_start; after en=1, next tick arrives after the remaining div count.
6. HS_POL=1, CLK_DIV=1; assert rst at h=300, v=200 → next clk h=799, v=524, valid=0, hsync=0; then h advances every clk.
